cla_slice_addsub_sequencer: RTL and testbench



---
 rtl/cla_slice_addsub_sequencer.sv | 117 +++++++++++
 tb/tb_cla_slice_addsub_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_addsub_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit carry-lookahead slice per clock, LSB slice first.
// Subtraction is A + ~B + 1, with the +1 injected as the initial slice carry.
module cla_slice_addsub_sequencer #(
    parameter int WIDTH = 15,
    parameter int SLICE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    base;
    logic [SLICE-1:0] sa, sb, g, p, sum;
    logic [SLICE:0]   c;
    logic             run_p, c_acc;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Each carry is a flat sum of products over the slice's g/p terms and the
    // incoming carry; no carry depends on another carry of the same slice.
    always_comb begin
        base  = IW'(cnt) * IW'(SLICE);
        sa    = a_reg[base +: SLICE];
        sb    = b_reg[base +: SLICE];
        g     = sa & sb;
        p     = sa ^ sb;
        c     = '0;
        c[0]  = carry_reg;
        run_p = 1'b1;
        c_acc = 1'b0;
        for (int i = 1; i <= SLICE; i++) begin
            run_p = 1'b1;
            c_acc = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                c_acc = c_acc | (g[j] & run_p);
                run_p = run_p & p[j];
            end
            c[i] = c_acc | (run_p & carry_reg);
        end
        sum = p ^ c[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= op_sub ? ~b_in : b_in;
                        carry_reg <= op_sub;
                        cnt       <= '0;
                    end
                end
                S_RUN: begin
                    result[base +: SLICE] <= sum;
                    carry_reg             <= c[SLICE];
                    cnt                   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        carry_out <= c[SLICE];
                        overflow  <= c[SLICE] ^ c[SLICE-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_slice_addsub_sequencer.sv
// Directed bench for cla_slice_addsub_sequencer: vector table plus multi-cycle
// sequences for ignored starts, continuous start, and reset during RUN.
module tb_cla_slice_addsub_sequencer;

    localparam int WIDTH = 15;
    localparam int SLICE = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a_in, b_in;
    logic             busy, done, carry_out, overflow;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } vec_t;

    vec_t vecs[12];

    cla_slice_addsub_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one operation; returns outputs at the done cycle, the negedge count
    // to done (6 expected) and the number of busy cycles seen.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] r, output logic co, output logic ov,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start  = 1'b1;
        op_sub = op;
        a_in   = a;
        b_in   = b;
        @(negedge clk);
        start    = 1'b0;
        op_sub   = 1'($urandom_range(0, 1));
        a_in     = WIDTH'($urandom_range(0, 32767));
        b_in     = WIDTH'($urandom_range(0, 32767));
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        r  = result;
        co = carry_out;
        ov = overflow;
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        logic             co, ov;
        int               lat, bc, seen, done_n, pulses, last_n;

        vecs[0]  = '{1'b0, 15'd100,    15'd200,    15'd300,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 15'd5,      15'd7,      15'h7FFE,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 15'd7,      15'd5,      15'd2,      1'b1, 1'b0};
        vecs[3]  = '{1'b0, 15'h3FFF,   15'h0001,   15'h4000,   1'b0, 1'b1};
        vecs[4]  = '{1'b0, 15'h7FFF,   15'h0001,   15'h0000,   1'b1, 1'b0};
        vecs[5]  = '{1'b0, 15'h7FFF,   15'h7FFF,   15'h7FFE,   1'b1, 1'b0};
        vecs[6]  = '{1'b1, 15'h4000,   15'h0001,   15'h3FFF,   1'b1, 1'b1};
        vecs[7]  = '{1'b0, 15'h1234,   15'h0FFF,   15'h2233,   1'b0, 1'b0};
        vecs[8]  = '{1'b1, 15'h0000,   15'h0000,   15'h0000,   1'b1, 1'b0};
        vecs[9]  = '{1'b1, 15'h4000,   15'h4000,   15'h0000,   1'b1, 1'b0};
        vecs[10] = '{1'b0, 15'h2AAA,   15'h1555,   15'h3FFF,   1'b0, 1'b0};
        vecs[11] = '{1'b1, 15'h0001,   15'h4000,   15'h4001,   1'b0, 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, co, ov, lat, bc);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd6);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            check($sformatf("vec%0d_carry", i), 32'(co), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_result_hold", i), 32'(result), 32'(vecs[i].res));
        end

        // 1 + 1 with extra start pulses during RUN and during DONE.
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a_in = 15'd1; b_in = 15'd1;
        seen = 0; done_n = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (done) begin
                seen++;
                done_n = n;
                check("ignore_result", 32'(result), 32'd2);
            end
            start  = (n == 3 || n == 6);
            op_sub = 1'b1; a_in = 15'd9; b_in = 15'd3;
        end
        start = 1'b0;
        check("ignore_done_count", 32'(seen), 32'd1);
        check("ignore_done_cycle", 32'(done_n), 32'd6);

        // Start held high: one operation every 7 cycles.
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a_in = 15'd3; b_in = 15'd4;
        pulses = 0; last_n = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held_result", 32'(result), 32'd7);
                if (last_n >= 0) check("held_period", 32'(n - last_n), 32'd7);
                else             check("held_first", 32'(n), 32'd6);
                last_n = n;
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd4);
        repeat (10) @(negedge clk);

        // Reset during slice 2 of 0x1234 + 0x0FFF.
        start = 1'b1; op_sub = 1'b0; a_in = 15'h1234; b_in = 15'h0FFF;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("partial_low_slices", 32'(result[5:0]), 32'h33);
        check("partial_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst_no_activity", 32'(seen), 32'd0);

        run_op(1'b0, 15'h1234, 15'h0FFF, r, co, ov, lat, bc);
        check("after_rst_latency", 32'(lat), 32'd6);
        check("after_rst_result", 32'(r), 32'h2233);
        check("after_rst_carry", 32'(co), 32'd0);
        check("after_rst_ovf", 32'(ov), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
